// File: rtl/seg7_pkg.sv
// Shared 7-segment constants: active-high code table, dp bit position,
// decoder input payload and a nibble lookup helper.
package seg7_pkg;

  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned SEG_W    = 8;
  localparam int unsigned DP_BIT   = 7;

  // Active-high g..a codes, entry 15 first so index n selects hex digit n.
  localparam logic [15:0][6:0] SEG7_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef struct packed {
    logic [NIBBLE_W-1:0] nibble;
    logic                dp;
    logic                blank;
  } seg7_in_t;

  function automatic logic [6:0] seg7_code(input logic [NIBBLE_W-1:0] nibble);
    return SEG7_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble/dp/blank to active-high segment pattern.
module seg7_decode
  import seg7_pkg::*;
(
  input  seg7_in_t         din,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = '0;
    if (!din.blank) begin
      seg_c[6:0]    = seg7_code(din.nibble);
      seg_c[DP_BIT] = din.dp;
    end
  end

endmodule

// File: rtl/display_scan_n.sv
// Multiplexed 7-segment scanner with frame-synchronous snapshot, per-digit
// blink, leading-zero blanking and freeze; all outputs registered.
module display_scan_n
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS          = 4,
  parameter bit          WEI_ACTIVE_LOW  = 1'b1,
  parameter bit          DUAN_ACTIVE_LOW = 1'b1,
  parameter int unsigned BLINK_HALF      = 50
) (
  input  logic                       clk_200Hz,
  input  logic                       rst,
  input  logic [NIBBLE_W*DIGITS-1:0] data,
  input  logic [DIGITS-1:0]          dot,
  input  logic [DIGITS-1:0]          blink,
  input  logic                       blank_lz,
  input  logic                       freeze,
  output logic [DIGITS-1:0]          sm_wei,
  output logic [SEG_W-1:0]           sm_duan,
  output logic                       frame_done
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CNT_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(BLINK_HALF - 1);
  localparam logic [DIGITS-1:0] WEI_OFF  = {DIGITS{WEI_ACTIVE_LOW}};
  localparam logic [SEG_W-1:0]  DUAN_OFF = {SEG_W{DUAN_ACTIVE_LOW}};

  logic [IDX_W-1:0]           idx, idx_nxt;
  logic [CNT_W-1:0]           blink_cnt, blink_cnt_nxt;
  logic                       phase, phase_nxt;
  logic [NIBBLE_W*DIGITS-1:0] data_q;
  logic [DIGITS-1:0]          dot_q;
  logic [DIGITS-1:0]          blink_q;
  logic                       phase_q;

  logic                       wrap;
  logic                       load;
  logic                       cnt_wrap;
  logic                       zero_above;
  logic [DIGITS-1:0]          lz_mask;
  logic [DIGITS-1:0]          onehot;
  seg7_in_t                   dec_in;
  logic [SEG_W-1:0]           seg_c;

  // Scan and blink counters; snapshot loads only on an unfrozen wrap edge.
  always_comb begin
    wrap          = (idx == LAST_IDX);
    load          = wrap && !freeze;
    idx_nxt       = wrap ? '0 : idx + IDX_W'(1);
    cnt_wrap      = (blink_cnt == LAST_CNT);
    blink_cnt_nxt = cnt_wrap ? '0 : blink_cnt + CNT_W'(1);
    phase_nxt     = phase ^ cnt_wrap;
  end

  // Digit i is leading-zero blanked when it and every higher digit carry no nibble and no dp.
  always_comb begin
    lz_mask    = '0;
    zero_above = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      zero_above = zero_above && (data_q[NIBBLE_W*i +: NIBBLE_W] == '0) && !dot_q[i];
      lz_mask[i] = blank_lz && (i > 0) && zero_above;
    end
  end

  always_comb begin
    onehot        = '0;
    onehot[idx]   = 1'b1;
    dec_in.nibble = NIBBLE_W'(data_q >> {idx, 2'b00});
    dec_in.dp     = dot_q[idx];
    dec_in.blank  = lz_mask[idx] || (blink_q[idx] && phase_q);
  end

  seg7_decode u_decode (
    .din   (dec_in),
    .seg_c (seg_c)
  );

  always_ff @(posedge clk_200Hz) begin
    if (rst) begin
      idx        <= '0;
      blink_cnt  <= '0;
      phase      <= 1'b0;
      data_q     <= '0;
      dot_q      <= '0;
      blink_q    <= '0;
      phase_q    <= 1'b0;
      sm_wei     <= WEI_OFF;
      sm_duan    <= DUAN_OFF;
      frame_done <= 1'b0;
    end else begin
      idx        <= idx_nxt;
      blink_cnt  <= blink_cnt_nxt;
      phase      <= phase_nxt;
      sm_wei     <= onehot ^ WEI_OFF;
      sm_duan    <= seg_c ^ DUAN_OFF;
      frame_done <= wrap;
      if (load) begin
        data_q  <= data;
        dot_q   <= dot;
        blink_q <= blink;
        phase_q <= phase;
      end
    end
  end

endmodule

// File: doc/display_scan_n.md
# display_scan_n

Parametrised multiplexed 7-segment scanner: next generation of the stopwatch `display` block. It drives `DIGITS` common-pin digits from a packed nibble bus, with per-digit decimal points, per-digit blink, runtime leading-zero blanking and a frame-synchronous `freeze` (lap/split hold). It sits between the stopwatch counter/control logic and the board's `sm_wei`/`sm_duan` pins, clocked by the existing scan clock.

## Interface
- `DIGITS`, 4: number of digits scanned, 1..16
- `WEI_ACTIVE_LOW`, 1: 1 = digit-select active low
- `DUAN_ACTIVE_LOW`, 1: 1 = segment/dp active low
- `BLINK_HALF`, 50: scan clocks per blink half-period, ≥1
- `clk_200Hz`  in  1  scan clock; one digit per cycle. Single clock domain.
- `rst`  in  1  synchronous, active-high reset
- `data`  in  4*DIGITS  hex nibble per digit; digit i = `data[4i+3:4i]`, digit 0 least significant
- `dot`  in  DIGITS  decimal point per digit
- `blink`  in  DIGITS  per-digit blink enable
- `blank_lz`  in  1  leading-zero blanking enable
- `freeze`  in  1  hold current snapshot
- `sm_wei`  out  DIGITS  digit select, bit i = digit i
- `sm_duan`  out  8  segments: [7]=dp, [6:0]=g..a
- `frame_done`  out  1  one-cycle pulse, last digit of a frame on outputs

## Operation
- Scan index `idx` (width max(1,$clog2(DIGITS))): 0..DIGITS-1, +1 per cycle, wraps to 0 after DIGITS-1.
- Snapshot registers `data_q`, `dot_q`, `blink_q`, `phase_q` load from the inputs and from the live blink phase only on the wrap edge (idx==DIGITS-1) and only when `freeze`==0. No mid-frame tearing. `freeze` is sampled only at the wrap edge.
- Blink counter counts 0..BLINK_HALF-1 every cycle. On reaching BLINK_HALF-1 it clears and toggles the live phase.
- Decode is active-high first, then inverted per the polarity parameters. Codes: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. dp = `dot_q[i]`.
- Digit i is blank (all segments and dp off; `sm_wei` still selects it) if either of these holds:
  - Leading-zero blank: `blank_lz`, i>0, and every digit j≥i has nibble 0 and dot 0. Digit 0 is never leading-zero blanked.
  - Blink blank: `blink_q[i]` and `phase_q`==1.
- `sm_wei`: exactly one bit active, at the bit for the digit being shown.

## Timing
- All outputs are registered. The edge that advances `idx` from k also registers the outputs for digit k, so outputs lag `idx` by one cycle.
- `frame_done` is registered high on the edge where idx==DIGITS-1, so it coincides with digit DIGITS-1 on the outputs.
- New input data appears on digit 0 on the outputs one cycle after the wrap edge that captured it. Worst case from input change to full display is 2·DIGITS cycles.
- Reset (any cycle, including mid-frame):
  - `idx`=0, snapshot=0, blink counter=0, phase=0.
  - `sm_wei` all inactive, `sm_duan` all off, `frame_done`=0.
- First cycle after `rst` falls: outputs show digit 0 of the zero snapshot. Live inputs appear from the second frame.
- DIGITS=1: every edge is a wrap edge, so the snapshot loads each cycle (when not frozen) and `frame_done` is high every cycle.
- `freeze` and a blink toggle on the same wrap edge: the snapshot and `phase_q` both hold, so blink stays frozen too.

## Structure
- `seg7_pkg`:
  - 16-entry active-high segment code constant
  - dp bit index (7)
  - function `seg7_code(nibble)`
- Sub-module `seg7_decode`: combinational nibble+dp+blank → 8-bit active-high segments. Polarity inversion is done in `display_scan_n` at the output registers.
- Blink counter and scan counter stay in `display_scan_n`.

## Test plan
Defaults unless stated: DIGITS=4, active-low.
- Reset: hold `rst` 3 cycles → `sm_wei`=4'hF, `sm_duan`=8'hFF, `frame_done`=0. After release, `sm_wei` cycles 1110,1101,1011,0111 and repeats; `frame_done` pulses with 0111.
- Decode: `data`=16'h1234, `dot`=4'b1000, `blank_lz`=0 → after a full frame:
  - digit0 = 8'h99 ('4')
  - digit1 = 8'hB0 ('3')
  - digit2 = 8'hA4 ('2')
  - digit3 = 8'h79 ('1' with dp on)
- Blanking: `blank_lz`=1.
  - `data`=16'h0050, `dot`=0 → digits 3 and 2 = 8'hFF, digit1 = 8'h92, digit0 = 8'hC0.
  - `data`=0 → only digit0 lit (8'hC0).
  - `dot`=4'b0100 with `data`=0 → digit3 = 8'hFF, digit2 = 8'h40.
- Freeze: show 16'h1234, raise `freeze`, drive 16'h9999 for 5 frames → display stays 1234. Drop `freeze` → 9999 appears on digit0 one cycle after the next wrap edge.
- Blink: BLINK_HALF=4, `blink`=4'b0001 → digit0 alternates between its code and 8'hFF, switching only at frame boundaries; digits 1-3 unaffected.
- Mid-frame reset: assert `rst` one cycle while digit2 is shown → next cycle outputs all off. After release, the scan restarts at digit0 with the zero snapshot.
